// File: rtl/fc_vector_streamer.sv
// fc_vector_streamer: buffers one flattened feature vector arriving from the
// last pooling stage (IN_CH words per beat) and replays it to the fully
// connected layer one word per cycle with valid/ready, index and last flag.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | just out of reset, one cycle before accepting input
// ST_FILL   | in_ready high, collecting beats until VEC_LEN words held
// ST_STREAM | out_valid high, presenting buf[rd_ptr] until last handshake
module fc_vector_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_CH      = 1,
  parameter int VEC_LEN    = 25,
  parameter int IDX_W      = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH*IN_CH-1:0] in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int PTR_W = $clog2(VEC_LEN + 1);
  localparam logic [PTR_W-1:0] VEC_END  = PTR_W'(VEC_LEN);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(VEC_LEN - 1);
  localparam logic [PTR_W-1:0] STEP     = PTR_W'(IN_CH);

  if (VEC_LEN % IN_CH != 0) begin : g_len_check
    $error("fc_vector_streamer: VEC_LEN must be a multiple of IN_CH");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic                   wr_en;
  logic                   in_fire;
  logic                   out_fire;
  logic [IDX_W-1:0]       wr_base;
  logic [DATA_WIDTH-1:0]  elem_d;
  logic [DATA_WIDTH-1:0]  vec_mem [VEC_LEN];

  assign wr_base  = wr_ptr_q[IDX_W-1:0];
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Next-state and pointer logic; flush overrides any handshake this cycle.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FILL;
      ST_FILL: begin
        if (in_fire) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + STEP;
          if (wr_ptr_d == VEC_END) begin
            state_d  = ST_STREAM;
            rd_ptr_d = '0;
          end
        end
      end
      ST_STREAM: begin
        if (out_fire) begin
          if (rd_ptr_q == LAST_IDX) begin
            state_d  = ST_FILL;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush && state_q != ST_IDLE) begin
      state_d  = ST_FILL;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      wr_en    = 1'b0;
    end
  end

  // Element for the next output register; bypasses the buffer when the word
  // is being written on this same edge (only when one beat fills the vector).
  always_comb begin
    elem_d = vec_mem[rd_ptr_d[IDX_W-1:0]];
    for (int k = 0; k < IN_CH; k++) begin
      if (wr_en && (wr_base + IDX_W'(k)) == rd_ptr_d[IDX_W-1:0]) begin
        elem_d = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Vector buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < IN_CH; k++) begin
        vec_mem[wr_base + IDX_W'(k)] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State, pointers and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      in_ready  <= (state_d == ST_FILL);
      out_valid <= (state_d == ST_STREAM);
      out_data  <= (state_d == ST_STREAM) ? elem_d : '0;
      out_index <= (state_d == ST_STREAM) ? rd_ptr_d[IDX_W-1:0] : '0;
      out_last  <= (state_d == ST_STREAM) && (rd_ptr_d == LAST_IDX);
      busy      <= (state_d == ST_STREAM) || (state_d == ST_FILL && wr_ptr_d != '0);
    end
  end

endmodule

// File: tb/tb_fc_vector_streamer.sv
// Bench for fc_vector_streamer: one instance with single-lane input, one with
// five lanes. Expected elements are queued as input words are driven and
// popped as the output side handshakes.
module tb_fc_vector_streamer;

  localparam int DW = 16;
  localparam int VL = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic [DW-1:0] in_data1 = '0;
  logic          in_ready1, out_valid1, out_last1, busy1;
  logic [DW-1:0] out_data1;
  logic [4:0]    out_index1;

  logic            flush5 = 1'b0, in_valid5 = 1'b0, out_ready5 = 1'b1;
  logic [5*DW-1:0] in_data5 = '0;
  logic            in_ready5, out_valid5, out_last5, busy5;
  logic [DW-1:0]   out_data5;
  logic [4:0]      out_index5;

  fc_vector_streamer #(.DATA_WIDTH(DW), .IN_CH(1), .VEC_LEN(VL)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1),
    .in_data(in_data1), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_data(out_data1), .out_index(out_index1), .out_last(out_last1),
    .out_ready(out_ready1), .busy(busy1)
  );

  fc_vector_streamer #(.DATA_WIDTH(DW), .IN_CH(5), .VEC_LEN(VL)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(flush5), .in_valid(in_valid5),
    .in_data(in_data5), .in_ready(in_ready5), .out_valid(out_valid5),
    .out_data(out_data5), .out_index(out_index5), .out_last(out_last5),
    .out_ready(out_ready5), .busy(busy5)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [4:0]    idx;
    logic          last;
  } exp_t;

  exp_t q1[$];
  exp_t q5[$];
  logic [DW-1:0] vec [VL];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, single-lane instance: {data,index,last} against queue head.
  always @(negedge clk) begin
    if (rst_n && out_valid1) begin
      if (q1.size() == 0) chk("s1_unexpected_valid", {31'd0, out_valid1}, 32'd0);
      else begin
        chk("s1_elem", {10'd0, out_data1, out_index1, out_last1}, {10'd0, q1[0]});
        if (out_ready1) void'(q1.pop_front());
      end
    end
  end

  // Output monitor, five-lane instance.
  always @(negedge clk) begin
    if (rst_n && out_valid5) begin
      if (q5.size() == 0) chk("s5_unexpected_valid", {31'd0, out_valid5}, 32'd0);
      else begin
        chk("s5_elem", {10'd0, out_data5, out_index5, out_last5}, {10'd0, q5[0]});
        if (out_ready5) void'(q5.pop_front());
      end
    end
  end

  task automatic beat1(input logic [DW-1:0] d);
    int n = 0;
    in_valid1 = 1'b1;
    in_data1  = d;
    while (!in_ready1 && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready1) chk("s1_in_ready_timeout", {31'd0, in_ready1}, 32'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
  endtask

  task automatic beat5(input logic [5*DW-1:0] d);
    int n = 0;
    in_valid5 = 1'b1;
    in_data5  = d;
    while (!in_ready5 && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready5) chk("s5_in_ready_timeout", {31'd0, in_ready5}, 32'd1);
    @(posedge clk); #1;
    in_valid5 = 1'b0;
  endtask

  task automatic send_vec1();
    for (int i = 0; i < VL; i++) begin
      q1.push_back('{data: vec[i], idx: 5'(i), last: (i == VL - 1)});
      beat1(vec[i]);
    end
  endtask

  task automatic drain1(input string tag, input int limit);
    int n = 0;
    while (q1.size() != 0 && n < limit) begin @(posedge clk); #1; n++; end
    chk({tag, "_drained"}, q1.size(), 32'd0);
  endtask

  initial begin
    int n;
    int held;
    logic [5*DW-1:0] lanes;

    // Reset values
    #12;
    chk("rst_in_ready", {31'd0, in_ready1}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    chk("rst_out_data", {16'd0, out_data1}, 32'd0);
    chk("rst_out_index", {27'd0, out_index1}, 32'd0);
    chk("rst_out_last", {31'd0, out_last1}, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("idle_in_ready", {31'd0, in_ready1}, 32'd0);
    @(posedge clk); #1;
    chk("fill_in_ready", {31'd0, in_ready1}, 32'd1);

    // Test 1: 1..25 with constant out_ready
    for (int i = 0; i < VL; i++) vec[i] = DW'(i + 1);
    send_vec1();
    chk("t1_in_ready_drop", {31'd0, in_ready1}, 32'd0);
    chk("t1_valid_latency", {31'd0, out_valid1}, 32'd1);
    chk("t1_first_data", {16'd0, out_data1}, 32'd1);
    chk("t1_busy", {31'd0, busy1}, 32'd1);
    n = 0;
    while (q1.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("t1_stream_cycles", n, 32'd25);
    chk("t1_gap_valid", {31'd0, out_valid1}, 32'd0);
    chk("t1_gap_last", {31'd0, out_last1}, 32'd0);
    chk("t1_gap_in_ready", {31'd0, in_ready1}, 32'd1);

    // Test 2: three stall cycles at index 7
    send_vec1();
    n = 0;
    held = 0;
    while (q1.size() != 0 && n < 100) begin
      if (out_valid1 && out_index1 == 5'd7) begin
        held++;
        out_ready1 = (held > 3);
      end else begin
        out_ready1 = 1'b1;
      end
      @(posedge clk); #1; n++;
    end
    out_ready1 = 1'b1;
    chk("t2_drained", q1.size(), 32'd0);
    chk("t2_held_cycles", held, 32'd4);

    // Test 3: five lanes per beat, lane0 = 5i
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 5; k++) begin
        lanes[k*DW +: DW] = DW'(5 * i + k);
        q5.push_back('{data: DW'(5 * i + k), idx: 5'(5 * i + k), last: (5 * i + k == VL - 1)});
      end
      beat5(lanes);
    end
    chk("t3_valid_latency", {31'd0, out_valid5}, 32'd1);
    chk("t3_busy", {31'd0, busy5}, 32'd1);
    n = 0;
    while (q5.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("t3_drained", q5.size(), 32'd0);

    // Test 4: signed extremes pass bit-exact
    vec[0] = 16'h8000;
    vec[1] = 16'hFFFF;
    vec[2] = 16'h7FFF;
    for (int i = 3; i < VL; i++) vec[i] = DW'($urandom);
    send_vec1();
    chk("t4_first_data", {16'd0, out_data1}, 32'h8000);
    drain1("t4", 100);

    // Test 5: flush after 10 words, with a beat offered during the flush
    for (int i = 0; i < 10; i++) beat1(DW'(16'h0A00 + i));
    chk("t5_busy_partial", {31'd0, busy1}, 32'd1);
    flush1    = 1'b1;
    in_valid1 = 1'b1;
    in_data1  = 16'hDEAD;
    @(posedge clk); #1;
    flush1    = 1'b0;
    in_valid1 = 1'b0;
    chk("t5_busy_after_flush", {31'd0, busy1}, 32'd0);
    chk("t5_in_ready_after_flush", {31'd0, in_ready1}, 32'd1);
    for (int i = 0; i < VL; i++) vec[i] = DW'(16'h0500 + 3 * i);
    for (int i = 0; i < VL; i++) begin
      chk("t5_no_early_valid", {31'd0, out_valid1}, 32'd0);
      q1.push_back('{data: vec[i], idx: 5'(i), last: (i == VL - 1)});
      beat1(vec[i]);
    end
    drain1("t5", 100);

    // Test 6: async reset at index 12 of the stream
    for (int i = 0; i < VL; i++) vec[i] = DW'(16'h1000 + i);
    send_vec1();
    n = 0;
    while (!(out_valid1 && out_index1 == 5'd12) && n < 100) begin @(posedge clk); #1; n++; end
    chk("t6_reach_idx12", {27'd0, out_index1}, 32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, out_valid1}, 32'd0);
    chk("t6_async_index", {27'd0, out_index1}, 32'd0);
    chk("t6_async_busy", {31'd0, busy1}, 32'd0);
    q1.delete();
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("t6_in_ready_release", {31'd0, in_ready1}, 32'd0);
    @(posedge clk); #1;
    chk("t6_in_ready_next", {31'd0, in_ready1}, 32'd1);
    for (int i = 0; i < VL; i++) vec[i] = DW'(16'h2000 - i);
    send_vec1();
    drain1("t6", 100);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
